// File: rtl/mtm_alu_sequencer_if.sv
// rtl/mtm_alu_sequencer_if.sv - byte input, core req/ack and response bundle for the ALU sequencer
interface mtm_alu_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_cmd;
    logic [7:0]  in_byte;

    logic        core_req;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [2:0]  core_op;
    logic        core_ack;
    logic [31:0] core_c;
    logic [7:0]  core_ctl;

    logic        out_valid;
    logic        out_ready;
    logic        out_is_err;
    logic [31:0] out_data;
    logic [7:0]  out_ctl;

    modport master (
        input  in_valid, in_is_cmd, in_byte,
        output in_ready,
        output core_req, core_a, core_b, core_op,
        input  core_ack, core_c, core_ctl,
        output out_valid, out_is_err, out_data, out_ctl,
        input  out_ready
    );

    modport slave (
        output in_valid, in_is_cmd, in_byte,
        input  in_ready,
        input  core_req, core_a, core_b, core_op,
        output core_ack, core_c, core_ctl,
        input  out_valid, out_is_err, out_data, out_ctl,
        output out_ready
    );
endinterface

// File: rtl/mtm_alu_sequencer.sv
// rtl/mtm_alu_sequencer.sv - frame assembly, CRC4/opcode checking and core handshake sequencing
module mtm_alu_sequencer #(
    parameter int TIMEOUT_CYC = 64,
    parameter int DATA_BYTES  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mtm_alu_sequencer_if.master  bus
);
    localparam int CNT_W = $clog2(DATA_BYTES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] TIMEOUT_CTL = 8'hFF;

    typedef enum logic [1:0] {COLLECT, CHECK, WAIT, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic             err_data;
    logic [63:0]      operands;
    logic [7:0]       cmd;
    logic [TMO_W-1:0] tmo_cnt;

    logic [3:0]       crc_calc;
    logic             len_bad;
    logic             crc_bad;
    logic             op_bad;
    logic [7:0]       check_ctl;

    // Serial LFSR form of x^4+x+1, zero seed, MSB of the message first.
    function automatic logic [3:0] crc4(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic [7:0] err_byte(input logic ed, input logic ec, input logic eo);
        logic [6:0] hi;
        hi = {1'b1, ed, ec, eo, ed, ec, eo};
        return {hi, ^hi};
    endfunction

    always_comb begin
        crc_calc  = crc4({operands, 1'b1, cmd[6:4]});
        len_bad   = err_data || (byte_cnt != CNT_W'(DATA_BYTES));
        crc_bad   = (crc_calc != cmd[3:0]);
        op_bad    = cmd[7] || cmd[5];
        check_ctl = err_byte(len_bad, !len_bad && crc_bad, !len_bad && !crc_bad && op_bad);
    end

    assign bus.core_b  = operands[63:32];
    assign bus.core_a  = operands[31:0];
    assign bus.core_op = cmd[6:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= COLLECT;
            byte_cnt       <= '0;
            err_data       <= 1'b0;
            operands       <= '0;
            cmd            <= '0;
            tmo_cnt        <= '0;
            bus.in_ready   <= 1'b0;
            bus.core_req   <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_is_err <= 1'b0;
            bus.out_data   <= '0;
            bus.out_ctl    <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        if (bus.in_is_cmd) begin
                            cmd          <= bus.in_byte;
                            bus.in_ready <= 1'b0;
                            state        <= CHECK;
                        end else if (byte_cnt < CNT_W'(DATA_BYTES)) begin
                            operands <= {operands[55:0], bus.in_byte};
                            byte_cnt <= byte_cnt + 1'b1;
                        end else begin
                            err_data <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (len_bad || crc_bad || op_bad) begin
                        bus.out_valid  <= 1'b1;
                        bus.out_is_err <= 1'b1;
                        bus.out_data   <= '0;
                        bus.out_ctl    <= check_ctl;
                        state          <= RESP;
                    end else begin
                        bus.core_req <= 1'b1;
                        tmo_cnt      <= '0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack landing on the final timeout cycle still counts as success.
                    if (bus.core_ack) begin
                        bus.core_req   <= 1'b0;
                        bus.out_valid  <= 1'b1;
                        bus.out_is_err <= 1'b0;
                        bus.out_data   <= bus.core_c;
                        bus.out_ctl    <= bus.core_ctl;
                        state          <= RESP;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        bus.core_req   <= 1'b0;
                        bus.out_valid  <= 1'b1;
                        bus.out_is_err <= 1'b1;
                        bus.out_data   <= '0;
                        bus.out_ctl    <= TIMEOUT_CTL;
                        state          <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        byte_cnt      <= '0;
                        err_data      <= 1'b0;
                        tmo_cnt       <= '0;
                        operands      <= '0;
                        state         <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_mtm_alu_sequencer.sv
// tb/tb_mtm_alu_sequencer.sv - scoreboard bench for mtm_alu_sequencer with a behavioural ALU core
module tb_mtm_alu_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    mtm_alu_sequencer_if bus();

    mtm_alu_sequencer #(.TIMEOUT_CYC(64), .DATA_BYTES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic [7:0]  ctl;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    int          ack_delay = 1;
    int          req_cnt = 0;
    int          req_rises = 0;
    int          req_start = 0;
    int          last_req_len = 0;
    int          ack_cyc = 0;
    int          cmd_cyc = 0;
    logic [31:0] seen_a, seen_b;
    logic [2:0]  seen_op;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Remainder of {msg, 0000} divided by 10011 over GF(2).
    function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'h0};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b100:  return a + b;
            default: return a - b;
        endcase
    endfunction

    function automatic logic [7:0] mk_cmd(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
        return {1'b0, op, ref_crc(b, a, op)};
    endfunction

    // Behavioural core: acks ack_delay cycles into core_req (0 = never).
    initial begin
        bus.core_ack = 1'b0;
        bus.core_c   = '0;
        bus.core_ctl = '0;
        forever begin
            @(negedge clk);
            bus.core_ack = 1'b0;
            if (bus.core_req === 1'b1) begin
                if (req_cnt == 0) begin
                    req_rises++;
                    req_start = cyc;
                    seen_a  = bus.core_a;
                    seen_b  = bus.core_b;
                    seen_op = bus.core_op;
                end
                req_cnt++;
                if (req_cnt == ack_delay) begin
                    check_eq("operands_stable", {bus.core_b, bus.core_a}, {seen_b, seen_a});
                    bus.core_ack = 1'b1;
                    bus.core_c   = ref_alu(bus.core_op, bus.core_a, bus.core_b);
                    bus.core_ctl = {5'b0, bus.core_op};
                    ack_cyc      = cyc + 1;
                end
            end else if (req_cnt != 0) begin
                last_req_len = req_cnt;
                req_cnt      = 0;
            end
        end
    end

    task automatic put_byte(input logic is_cmd, input logic [7:0] b);
        int n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_is_cmd = is_cmd;
        bus.in_byte   = b;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check_eq("in_ready_wait", 0, 1);
        else if (is_cmd) cmd_cyc = cyc;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_is_cmd = 1'b0;
    endtask

    task automatic send_frame(input int nbytes, input logic [31:0] b, input logic [31:0] a, input logic [7:0] cmd);
        exp_t        e;
        logic [63:0] d;
        logic [2:0]  op;
        d  = {b, a};
        op = cmd[6:4];
        e.data = '0;
        if (nbytes != 8) begin
            e.err = 1'b1; e.ctl = 8'hC9; e.lat = 1;
        end else if (cmd[3:0] != ref_crc(b, a, op)) begin
            e.err = 1'b1; e.ctl = 8'hA5; e.lat = 1;
        end else if (cmd[7] || !(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101)) begin
            e.err = 1'b1; e.ctl = 8'h93; e.lat = 1;
        end else if (ack_delay < 1 || ack_delay > 64) begin
            e.err = 1'b1; e.ctl = 8'hFF; e.lat = 0;
        end else begin
            e.err = 1'b0; e.ctl = {5'b0, op}; e.data = ref_alu(op, a, b); e.lat = 2;
        end
        sb.push_back(e);
        for (int i = 0; i < nbytes; i++)
            put_byte(1'b0, (i < 8) ? d[63 - 8*i -: 8] : 8'hEE);
        put_byte(1'b1, cmd);
    endtask

    task automatic get_resp(input int hold);
        exp_t        e;
        int          n;
        logic [31:0] d0;
        logic [7:0]  c0;
        logic        e0;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            check_eq("resp_wait", 0, 1);
            return;
        end
        if (sb.size() == 0) begin
            check_eq("unexpected_resp", 1, 0);
            return;
        end
        e = sb.pop_front();
        if (e.lat == 1) check_eq("err_latency", cyc, cmd_cyc + 2);
        if (e.lat == 2) check_eq("ack_latency", cyc, ack_cyc);
        check_eq("out_is_err", bus.out_is_err, e.err);
        check_eq("out_ctl", bus.out_ctl, e.ctl);
        if (!e.err) check_eq("out_data", bus.out_data, e.data);
        d0 = bus.out_data;
        c0 = bus.out_ctl;
        e0 = bus.out_is_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", bus.out_valid, 1);
            check_eq("hold_values", {bus.out_is_err, bus.out_ctl, bus.out_data}, {e0, c0, d0});
            check_eq("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("valid_after_hs", bus.out_valid, 0);
    endtask

    initial begin
        int rises0;
        int n;
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        logic [2:0]  ops [4];
        ops = '{3'b000, 3'b001, 3'b100, 3'b101};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_is_cmd = 1'b0;
        bus.in_byte   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_core_req", bus.core_req, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_outputs", {bus.out_is_err, bus.out_ctl, bus.out_data}, 0);
        check_eq("rst_core_bus", {bus.core_op, bus.core_a, bus.core_b}, 0);
        rst = 1'b0;

        ack_delay = 3;
        send_frame(8, 32'h1, 32'h2, mk_cmd(32'h1, 32'h2, 3'b100));
        get_resp(0);
        check_eq("req_latency", req_start, cmd_cyc + 2);
        check_eq("core_a", seen_a, 32'h2);
        check_eq("core_b", seen_b, 32'h1);
        check_eq("core_op", seen_op, 3'b100);

        rises0 = req_rises;
        send_frame(7, 32'h11223344, 32'h55667788, mk_cmd(32'h11223344, 32'h55667788, 3'b100));
        get_resp(0);
        send_frame(0, 32'h0, 32'h0, mk_cmd(32'h0, 32'h0, 3'b000));
        get_resp(0);
        send_frame(9, 32'hA, 32'hB, mk_cmd(32'hA, 32'hB, 3'b001));
        get_resp(0);
        send_frame(8, 32'hDEADBEEF, 32'h12345678, mk_cmd(32'hDEADBEEF, 32'h12345678, 3'b101) ^ 8'h01);
        get_resp(0);
        send_frame(8, 32'h5, 32'h6, mk_cmd(32'h5, 32'h6, 3'b010));
        get_resp(0);
        send_frame(8, 32'h7, 32'h8, mk_cmd(32'h7, 32'h8, 3'b100) | 8'h80);
        get_resp(0);
        check_eq("no_req_on_err", req_rises, rises0);

        ack_delay = 0;
        send_frame(8, 32'h9, 32'h1, mk_cmd(32'h9, 32'h1, 3'b100));
        get_resp(0);
        check_eq("timeout_req_len", last_req_len, 64);

        ack_delay = 64;
        send_frame(8, 32'h100, 32'h23, mk_cmd(32'h100, 32'h23, 3'b101));
        get_resp(0);
        check_eq("ack_at_limit_len", last_req_len, 64);

        ack_delay = 2;
        send_frame(8, 32'hF0F0F0F0, 32'h0FF00FF0, mk_cmd(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000));
        get_resp(10);

        bus.out_ready = 1'b1;
        send_frame(8, 32'h3, 32'h4, mk_cmd(32'h3, 32'h4, 3'b001));
        get_resp(0);

        for (int k = 0; k < 6; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = ops[$urandom_range(0, 3)];
            ack_delay = $urandom_range(1, 6);
            send_frame(8, rb, ra, mk_cmd(rb, ra, rop));
            get_resp($urandom_range(0, 3));
        end

        ack_delay = 0;
        send_frame(8, 32'h2, 32'h2, mk_cmd(32'h2, 32'h2, 3'b100));
        n = 0;
        while (!bus.core_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_before_rst", bus.core_req, 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_drops_req", bus.core_req, 0);
        check_eq("rst_drops_valid", bus.out_valid, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 4;
        send_frame(8, 32'hCAFE0000, 32'h0000BABE, mk_cmd(32'hCAFE0000, 32'h0000BABE, 3'b100));
        get_resp(0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mtm_alu_sequencer.md
Name: mtm_alu_sequencer

Overview:
- Sits between the serial-frame receiver and the ALU core.
- Assembles byte-level input frames into operands B and A plus a command, then checks frame length, CRC4 and opcode.
- Issues valid operations to the core over a req/ack handshake and forwards the core result, or an error response, to the serializer through a valid/ready output.
- Never reorders frames; exactly one operation is in flight at a time.

Parameters:
- TIMEOUT_CYC, 64: maximum cycles from core_req assertion to core_ack before a timeout response is produced.
- DATA_BYTES, 8: data bytes per frame; B first, then A, 4 bytes each, MSB first.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input byte valid.
- in_ready  out  1  sequencer accepts a byte; transfer occurs when in_valid and in_ready are both 1.
- in_is_cmd  in  1  1 = command byte, 0 = data byte.
- in_byte  in  8  byte payload.
- core_req  out  1  operation request, held high until core_ack.
- core_a  out  32  operand A.
- core_b  out  32  operand B.
- core_op  out  3  opcode.
- core_ack  in  1  one-cycle pulse; core_c and core_ctl are valid in this cycle.
- core_c  in  32  core result.
- core_ctl  in  8  core status byte {0, flags[3:0], crc3}.
- out_valid  out  1  response valid, held until out_ready.
- out_ready  in  1  downstream accepts the response.
- out_is_err  out  1  1 = error response; out_data is don't-care.
- out_data  out  32  result C.
- out_ctl  out  8  status byte: core_ctl on success, error byte otherwise.

Behaviour:
- **Reset values.** On rst, all outputs are 0 and state is COLLECT. All counters, the error-pending bit and the operand registers are cleared. Reset mid-operation abandons the frame: no response is emitted and core_req drops immediately.
- **COLLECT state.** in_ready = 1.
  - A data byte shifts into {B,A} while byte count < DATA_BYTES, and the count increments.
  - A data byte arriving at count == DATA_BYTES sets err_data; the byte is discarded and the count saturates.
  - A command byte moves the state to CHECK and clears in_ready from the next cycle.
- **Command byte format.** {bit7, OP[2:0], CRC[3:0]}.
- **CHECK state (1 cycle).** Checks are mutually exclusive, highest priority first:
  1. err_data set, or count != DATA_BYTES → ERR_DATA.
  2. CRC4 mismatch → ERR_CRC.
  3. bit7 == 1, or OP not in {000, 001, 100, 101} → ERR_OP.
  4. Otherwise go to ISSUE.
  - Any error goes to RESP with out_is_err = 1.
- **CRC4 definition.**
  - Polynomial x^4+x+1, initial value 0.
  - Computed over 68 bits {B, A, 1'b1, OP}, MSB first (B[31] first).
  - Byte-wise incremental or single-shot computation is permitted; the result must be identical.
- **ISSUE/WAIT states.**
  - core_req rises in the cycle after CHECK; core_a, core_b and core_op are stable while core_req = 1.
  - On core_ack: capture core_c and core_ctl, drop core_req the next cycle, go to RESP.
  - A timeout counter starts at core_req rise. If it reaches TIMEOUT_CYC without core_ack: drop core_req and go to RESP with out_ctl = 8'hFF and out_is_err = 1.
  - core_ack outside WAIT is ignored.
- **RESP state.**
  - out_valid = 1 and held, with out_data, out_ctl and out_is_err stable, until out_ready.
  - On handshake, the next cycle has out_valid = 0, counters cleared, state COLLECT.
- **Error byte.** {1, ED, EC, EO, ED, EC, EO, P}.
  - ED, EC and EO are the ERR_DATA, ERR_CRC and ERR_OP flags.
  - P is even parity over bits 7:1.
  - Resulting codes: ERR_DATA → 8'hC9, ERR_CRC → 8'hA5, ERR_OP → 8'h93.
- **Latency.** Command byte accepted at cycle T → core_req at T+2. core_ack at cycle U → out_valid at U+1. Error path: out_valid at T+2.
- **Boundary conditions.**
  - A command byte with zero data bytes gives ERR_DATA.
  - in_valid while in_ready = 0 is not consumed; the upstream holds the byte.
  - out_ready asserted before out_valid has no effect.
  - core_ack in the same cycle the timeout expires counts as success (ack wins).

Test Plan:
- **Normal ADD.** B = 32'h0000_0001, A = 32'h0000_0002, OP = 100 with correct CRC. Core acks with core_c = 3, core_ctl = 8'h0X. Required: core_req at T+2 with core_a = 2, core_b = 1; then out_valid, out_is_err = 0, out_data = 3, out_ctl = core_ctl.
- **Short frame.** 7 data bytes then a command byte. Required: out_is_err = 1, out_ctl = 8'hC9, and core_req never asserted.
- **CRC and opcode errors.**
  - 8 data bytes with CRC field XOR 4'h1 → out_ctl = 8'hA5.
  - Valid CRC with OP = 010 → out_ctl = 8'h93.
- **Timeout.** TIMEOUT_CYC = 64 and core_ack never asserted. Required: core_req high exactly 64 cycles, then out_ctl = 8'hFF with out_is_err = 1.
- **Backpressure.** out_ready held low for 10 cycles. Required: out_valid and all output values stable; in_ready = 0 throughout; the next frame is accepted only after the handshake.
- **Reset mid-operation.** Assert rst during WAIT, asynchronously and between clock edges. Required: core_req and out_valid drop immediately; a following full frame is processed normally.
